// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped, write-back data cache.
// The controller and its tag store both derive their field widths from here.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL
    } state_e;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    localparam int OFFSET_W = 2;

    function automatic int tag_width(input int width, input int sets);
        return width - $clog2(sets) - OFFSET_W;
    endfunction

    // Word beats half beats byte when the pipeline raises several size strobes.
    function automatic size_e size_sel(input logic sw, input logic sh, input logic sb);
        if (sw)      return SZ_WORD;
        else if (sh) return SZ_HALF;
        else if (sb) return SZ_BYTE;
        else         return SZ_NONE;
    endfunction

endpackage

// File: rtl/dcache_tag_store.sv
// Valid/dirty/tag bookkeeping for the data cache: one entry per line, looked up
// and updated through a single index port. Tags are not reset; valid/dirty are.
module dcache_tag_store
    import dcache_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             fill_i,
    input  logic             dirty_set_i,
    input  logic             dirty_clr_i,
    output logic             valid_o,
    output logic             dirty_o,
    output logic             match_o,
    output logic [TAG_W-1:0] tag_o
);

    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;
    logic [TAG_W-1:0] tag_q [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (dirty_set_i) begin
            dirty_q[idx_i] <= 1'b1;
        end else if (dirty_clr_i) begin
            dirty_q[idx_i] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[idx_i] <= tag_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign match_o = valid_q[idx_i] && (tag_q[idx_i] == tag_i);

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller: hit-path store
// merge, victim writeback and refill over a req/ack handshake, pipeline stall.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic             sw,
    input  logic             sh,
    input  logic             sb,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
);

    localparam int TAG_W = tag_width(WIDTH, SETS);

    state_e           state_q, state_d;
    logic             replay_q, replay_d;
    logic [WIDTH-1:0] cap_addr_q, cap_wdata_q;
    logic             cap_we_q;
    size_e            cap_size_q;
    logic [TAG_W-1:0] vic_tag_q;
    logic [WIDTH-1:0] vic_data_q;
    logic [31:0]      hit_cnt_q, miss_cnt_q;
    logic [WIDTH-1:0] data_q [SETS];

    logic             use_cap;
    logic [WIDTH-1:0] eff_addr, eff_wdata, line, data_wval;
    logic             eff_we;
    size_e            eff_size;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag, line_tag;
    logic             line_valid, line_dirty, line_match, hit;
    logic             stall_c, capture, count_hit, count_miss;
    logic             data_we, fill, dirty_set, dirty_clr;

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_word,
                                               input logic [WIDTH-1:0] wdata,
                                               input size_e size,
                                               input logic [1:0] off);
        logic [WIDTH-1:0] res;
        res = old_word;
        case (size)
            SZ_WORD: res = wdata;
            SZ_HALF: begin
                if (off[1]) res[31:16] = wdata[15:0];
                else        res[15:0]  = wdata[15:0];
            end
            SZ_BYTE: res[{off, 3'b000} +: 8] = wdata[7:0];
            default: ;
        endcase
        return res;
    endfunction

    // While a miss is in flight (and in its replay cycle) the captured request drives the lookup.
    assign use_cap   = (state_q != IDLE) || replay_q;
    assign eff_addr  = use_cap ? cap_addr_q  : cpu_addr;
    assign eff_wdata = use_cap ? cap_wdata_q : cpu_wdata;
    assign eff_we    = use_cap ? cap_we_q    : cpu_we;
    assign eff_size  = use_cap ? cap_size_q  : size_sel(sw, sh, sb);
    assign idx       = eff_addr[IDX_W+1:2];
    assign tag       = eff_addr[WIDTH-1:IDX_W+2];
    assign line      = data_q[idx];
    assign hit       = cpu_req && line_match;

    dcache_tag_store #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tags (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_i       (idx),
        .tag_i       (tag),
        .fill_i      (fill),
        .dirty_set_i (dirty_set),
        .dirty_clr_i (dirty_clr),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .match_o     (line_match),
        .tag_o       (line_tag)
    );

    always_comb begin
        state_d    = state_q;
        replay_d   = replay_q;
        stall_c    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_rdata  = '0;
        capture    = 1'b0;
        count_hit  = 1'b0;
        count_miss = 1'b0;
        data_we    = 1'b0;
        data_wval  = merge(line, eff_wdata, eff_size, eff_addr[1:0]);
        fill       = 1'b0;
        dirty_set  = 1'b0;
        dirty_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                replay_d = 1'b0;
                if (hit) begin
                    cpu_rdata = line;
                    count_hit = !replay_q;
                    if (eff_we && (eff_size != SZ_NONE)) begin
                        data_we   = 1'b1;
                        dirty_set = 1'b1;
                    end
                end else if (cpu_req) begin
                    stall_c    = 1'b1;
                    capture    = 1'b1;
                    count_miss = 1'b1;
                    state_d    = (line_valid && line_dirty) ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                stall_c   = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vic_tag_q, idx, 2'b00};
                mem_wdata = vic_data_q;
                if (mem_ack) begin
                    dirty_clr = 1'b1;
                    state_d   = REFILL;
                end
            end
            REFILL: begin
                stall_c   = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {tag, idx, 2'b00};
                data_wval = mem_rdata;
                if (mem_ack) begin
                    fill     = 1'b1;
                    data_we  = 1'b1;
                    replay_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset must drop the freeze immediately, even while a request is still presented.
    assign stall      = stall_c && rst_n;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            replay_q    <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            cap_we_q    <= 1'b0;
            cap_size_q  <= SZ_NONE;
            vic_tag_q   <= '0;
            vic_data_q  <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            replay_q <= replay_d;
            if (capture) begin
                cap_addr_q  <= cpu_addr;
                cap_wdata_q <= cpu_wdata;
                cap_we_q    <= cpu_we;
                cap_size_q  <= size_sel(sw, sh, sb);
                vic_tag_q   <= line_tag;
                vic_data_q  <= line;
            end
            if (count_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (count_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[idx] <= data_wval;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: a transaction-queue cache model is
// compared against the DUT every cycle, plus directed hand-computed checks.
module tb_dcache_controller;

    localparam int WIDTH = 32;
    localparam int SETS  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, sw = 1'b0, sh = 1'b0, sb = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata, hit_count, miss_count;
    logic        stall, mem_req, mem_we;

    int passCount = 0;
    int totalCount = 0;

    dcache_controller #(.WIDTH(WIDTH), .SETS(SETS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .sw         (sw),
        .sh         (sh),
        .sb         (sb),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        else
            passCount++;
    endtask

    // Model: lines as word addresses plus a queue of memory transactions still owed.
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        pend[$];
    txn_t        mT;
    bit          mValid[SETS];
    bit          mDirty[SETS];
    logic [31:0] mWordAddr[SETS];
    logic [31:0] mData[SETS];
    bit          mReplay;
    logic [31:0] capAddr, capData;
    bit          capWe, capSw, capSh, capSb;
    logic [31:0] mHits, mMisses;
    logic [31:0] mA, mW;
    bit          mWe, mSw, mSh, mSb, mWasReplay;
    int          mSet, mLane, mBytes;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SETS; i++) begin
                mValid[i] = 0;
                mDirty[i] = 0;
            end
            pend.delete();
            mReplay = 0;
            mHits   = 0;
            mMisses = 0;
        end else if (pend.size() > 0) begin
            if (mem_ack) begin
                mT   = pend.pop_front();
                mSet = int'(mT.addr >> 2) % SETS;
                if (mT.we) begin
                    mDirty[mSet] = 0;
                end else begin
                    mValid[mSet]    = 1;
                    mDirty[mSet]    = 0;
                    mWordAddr[mSet] = mT.addr >> 2;
                    mData[mSet]     = mem_rdata;
                    mReplay         = 1;
                end
            end
        end else begin
            mWasReplay = mReplay;
            mReplay    = 0;
            if (cpu_req) begin
                mA   = mWasReplay ? capAddr : cpu_addr;
                mW   = mWasReplay ? capData : cpu_wdata;
                mWe  = mWasReplay ? capWe : cpu_we;
                mSw  = mWasReplay ? capSw : sw;
                mSh  = mWasReplay ? capSh : sh;
                mSb  = mWasReplay ? capSb : sb;
                mSet = int'(mA >> 2) % SETS;
                if (mValid[mSet] && mWordAddr[mSet] == (mA >> 2)) begin
                    if (!mWasReplay) mHits = mHits + 1;
                    mBytes = mSw ? 4 : mSh ? 2 : mSb ? 1 : 0;
                    mLane  = mSw ? 0 : mSh ? 2 * int'(mA[1]) : int'(mA[1:0]);
                    if (mWe) begin
                        for (int k = 0; k < mBytes; k++)
                            mData[mSet][(mLane + k) * 8 +: 8] = mW[k * 8 +: 8];
                        if (mBytes > 0) mDirty[mSet] = 1;
                    end
                end else begin
                    mMisses = mMisses + 1;
                    capAddr = cpu_addr; capData = cpu_wdata; capWe = cpu_we;
                    capSw = sw; capSh = sh; capSb = sb;
                    if (mValid[mSet] && mDirty[mSet])
                        pend.push_back('{1'b1, mWordAddr[mSet] << 2, mData[mSet]});
                    pend.push_back('{1'b0, {mA[31:2], 2'b00}, 32'h0});
                end
            end
        end
    end

    // Compare every cycle, mid-way between rising edges.
    logic [31:0] eRdata, eAddr, eWdata, eA;
    logic        eStall, eReq, eWe;
    int          eSet;

    always @(negedge clk) begin
        eStall = 0; eReq = 0; eWe = 0; eAddr = 0; eWdata = 0; eRdata = 0;
        if (rst_n) begin
            if (pend.size() > 0) begin
                eStall = 1;
                eReq   = 1;
                eWe    = pend[0].we;
                eAddr  = pend[0].addr;
                eWdata = pend[0].we ? pend[0].wdata : 32'h0;
            end else if (cpu_req) begin
                eA   = mReplay ? capAddr : cpu_addr;
                eSet = int'(eA >> 2) % SETS;
                if (mValid[eSet] && mWordAddr[eSet] == (eA >> 2)) eRdata = mData[eSet];
                else eStall = 1;
            end
        end
        checkOutput("cyc stall", stall, eStall);
        checkOutput("cyc mem_req", mem_req, eReq);
        checkOutput("cyc mem_we", mem_we, eWe);
        checkOutput("cyc mem_addr", mem_addr, eAddr);
        checkOutput("cyc mem_wdata", mem_wdata, eWdata);
        checkOutput("cyc cpu_rdata", cpu_rdata, eRdata);
        checkOutput("cyc hit_count", hit_count, mHits);
        checkOutput("cyc miss_count", miss_count, mMisses);
    end

    logic [31:0] wbFirstAddr, wbFirstData, rfFirstAddr;
    int          wbUnstable;

    // One CPU access from start to its completing (non-stalled) cycle, acking memory on schedule.
    task automatic applyStimulus(input string label, input logic we, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int wbDelay, input int rfDelay, input logic [31:0] rfData,
                                 input int expStall, input bit chkRdata, input logic [31:0] expRdata);
        int          stallCycles, waitCnt, prevKind, kind;
        bit          done;
        logic [31:0] seenRdata;
        stallCycles = 0; waitCnt = 0; prevKind = -1; done = 0; seenRdata = 0;
        cpu_req = 1; cpu_we = we; {sw, sh, sb} = size; cpu_addr = addr; cpu_wdata = wdata;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            if (!stall) begin
                done = 1;
                seenRdata = cpu_rdata;
            end else begin
                stallCycles++;
                if (mem_req) begin
                    kind = mem_we ? 1 : 0;
                    if (kind != prevKind) begin
                        waitCnt = 0;
                        prevKind = kind;
                        if (kind == 1) begin
                            wbFirstAddr = mem_addr;
                            wbFirstData = mem_wdata;
                        end else begin
                            rfFirstAddr = mem_addr;
                        end
                    end else if (kind == 1 && (mem_addr !== wbFirstAddr || mem_wdata !== wbFirstData)) begin
                        wbUnstable++;
                    end
                    if (waitCnt == (kind == 1 ? wbDelay : rfDelay)) begin
                        mem_ack = 1;
                        mem_rdata = rfData;
                    end
                    waitCnt++;
                end
            end
            @(posedge clk); #2;
            mem_ack = 0;
            if (stallCycles > 0 && !done) begin
                cpu_addr  = addr ^ 32'h0000_0F0C;
                cpu_wdata = ~wdata;
            end
        end
        cpu_req = 0; cpu_we = 0; {sw, sh, sb} = 3'b000;
        checkOutput({label, " completed"}, done, 1);
        checkOutput({label, " stall cycles"}, stallCycles, expStall);
        if (chkRdata) checkOutput({label, " rdata"}, seenRdata, expRdata);
    endtask

    bit found;

    initial begin
        wbUnstable = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset stall", stall, 0);
        checkOutput("reset mem_req", mem_req, 0);
        checkOutput("reset hit_count", hit_count, 0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        applyStimulus("cold load", 0, 3'b000, 32'h10, 0, 0, 3, 32'hDEADBEEF, 5, 1, 32'hDEADBEEF);
        checkOutput("cold refill addr", rfFirstAddr, 32'h10);
        checkOutput("cold miss_count", miss_count, 1);
        checkOutput("cold hit_count", hit_count, 0);

        applyStimulus("sb hit", 1, 3'b001, 32'h13, 32'h0000_00AA, 0, 0, 0, 0, 0, 0);
        applyStimulus("sh hit", 1, 3'b010, 32'h10, 32'h0000_1234, 0, 0, 0, 0, 0, 0);
        applyStimulus("load merged", 0, 3'b000, 32'h10, 0, 0, 0, 0, 0, 1, 32'hAAAD1234);
        checkOutput("merged hit_count", hit_count, 3);

        applyStimulus("conflict load", 0, 3'b000, 32'h30, 0, 10, 2, 32'h0BADF00D, 15, 1, 32'h0BADF00D);
        checkOutput("wb addr", wbFirstAddr, 32'h10);
        checkOutput("wb data", wbFirstData, 32'hAAAD1234);
        checkOutput("wb stable", wbUnstable, 0);
        checkOutput("conflict refill addr", rfFirstAddr, 32'h30);
        checkOutput("conflict miss_count", miss_count, 2);

        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h50;
        found = 0;
        for (int cyc = 0; cyc < 50 && !found; cyc++) begin
            #1;
            if (mem_req && !mem_we) found = 1;
            @(posedge clk); #2;
        end
        checkOutput("rst reached refill", found, 1);
        @(posedge clk); #3;
        checkOutput("rst refill addr", mem_addr, 32'h50);
        rst_n = 1'b0;
        #1;
        checkOutput("rst mem_req", mem_req, 0);
        checkOutput("rst stall", stall, 0);
        checkOutput("rst hit_count", hit_count, 0);
        checkOutput("rst miss_count", miss_count, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        cpu_req = 0;
        @(posedge clk); #2;

        applyStimulus("post-reset load", 0, 3'b000, 32'h50, 0, 0, 1, 32'h5050_5050, 3, 1, 32'h5050_5050);
        checkOutput("post-reset miss_count", miss_count, 1);

        applyStimulus("store miss all sizes", 1, 3'b111, 32'h44, 32'h11223344, 0, 0, 32'hFFFF_FFFF, 2, 0, 0);
        applyStimulus("load sw result", 0, 3'b000, 32'h44, 0, 0, 0, 0, 0, 1, 32'h11223344);
        applyStimulus("store no size", 1, 3'b000, 32'h44, 32'h0, 0, 0, 0, 0, 0, 0);
        applyStimulus("sh upper", 1, 3'b010, 32'h47, 32'hFFFF_BEEF, 0, 0, 0, 0, 0, 0);
        applyStimulus("sb lane1", 1, 3'b001, 32'h45, 32'h1234_5655, 0, 0, 0, 0, 0, 0);
        applyStimulus("load partial", 0, 3'b000, 32'h44, 0, 0, 0, 0, 0, 1, 32'hBEEF5544);

        mem_ack = 1;
        @(posedge clk); #2;
        mem_ack = 0;
        @(posedge clk); #2;
        checkOutput("final hit_count", hit_count, 5);
        checkOutput("final miss_count", miss_count, 2);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Sequencing controller for the data cache in the memory stage.
- Direct-mapped, write-back, write-allocate cache with one 32-bit word per line.
- Owns the tag, valid and dirty state and the data array. Performs the hit-path byte/half/word store merge. Runs writeback and refill transactions to main memory over a req/ack handshake.
- Stalls the pipeline while a miss is serviced.

Parameters:
- WIDTH, 32, data and address width.
- SETS, 8, number of lines; must be a power of 2.
- IDX_W, $clog2(SETS), index width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  memory-stage access valid.
- cpu_we  in  1  1 = store, 0 = load.
- sw, sh, sb  in  1 each  store size; priority sw > sh > sb.
- cpu_addr  in  WIDTH  byte address.
- cpu_wdata  in  WIDTH  store data, right-aligned.
- cpu_rdata  out  WIDTH  full line word for loads; extension is done downstream.
- stall  out  1  freeze pipeline.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = writeback, 0 = refill.
- mem_addr  out  WIDTH  word-aligned address {tag, index, 2'b00}.
- mem_wdata  out  WIDTH  victim data.
- mem_rdata  in  WIDTH  refill data.
- mem_ack  in  1  one-cycle completion pulse.
- hit_count  out  32  lookups that hit.
- miss_count  out  32  lookups that missed.

Behaviour:
- Address split:
  - offset = addr[1:0]
  - index = addr[IDX_W+1:2]
  - tag = addr[WIDTH-1:IDX_W+2]
- Reset (async, rst_n=0):
  - All valid and dirty bits cleared; state IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - stall=0, cpu_rdata=0 when no hit.
  - Counters = 0, replay flag = 0.
  - Data and tag arrays are not reset.
  - Reset mid-transaction aborts it; dirty data is discarded.
- hit = cpu_req & valid[index] & (tag_array[index] == tag).
- IDLE:
  - Lookup is combinational in the same cycle.
  - Load hit: cpu_rdata = line word, stall = 0.
  - Store hit: stall = 0. At the clock edge, line <= merge(line, cpu_wdata) and dirty <= 1.
  - Merge rules:
    - sw: full word.
    - sh: addr[1] selects the half; addr[0] is ignored.
    - sb: addr[1:0] selects the byte lane; all other bits are kept.
  - Store with none of sw/sh/sb set: line unchanged and dirty unchanged. Counted as a hit.
  - Miss with victim valid and dirty: stall = 1, next state WRITEBACK, latch the victim address and data.
  - Miss otherwise: stall = 1, next state REFILL.
  - cpu_req = 0: no state change, stall = 0.
- WRITEBACK:
  - mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, 00}, mem_wdata = victim word.
  - All held stable until mem_ack.
  - On mem_ack: clear dirty, go to REFILL.
- REFILL:
  - mem_req = 1, mem_we = 0, mem_addr = {request tag, index, 00}.
  - On mem_ack: write mem_rdata to the line, set tag, valid = 1, dirty = 0. Set replay = 1, go to IDLE.
- Replay:
  - The first IDLE cycle after a refill re-performs the lookup and hits.
  - stall is low in that cycle and a store merges then.
  - Miss latency: 1 + writeback ack wait + refill ack wait + 1 replay cycle.
- stall is high in WRITEBACK and REFILL regardless of mem_ack.
- The request address, data and size are captured at miss detection. Controller-internal requests use the captured copy, so the cpu_* inputs may change during the miss.
- If cpu_req drops mid-miss, the transaction still completes and the line is installed. The replay cycle performs no access and no count.
- Counters:
  - hit_count increments on an IDLE hit with replay = 0.
  - miss_count increments on the IDLE→WRITEBACK or IDLE→REFILL transition.
  - Replay hits are not counted; replay clears after one IDLE cycle.
  - Counters wrap modulo 2^32.
- mem_ack outside WRITEBACK/REFILL is ignored.

Decomposition:
- Shared package dcache_pkg:
  - State enum {IDLE, WRITEBACK, REFILL}.
  - Tag/index/offset width constants derived from WIDTH and SETS.
  - Size-select encoding.
- One natural sub-module, dcache_tag_store: valid/dirty/tag arrays with async clear and index lookup/compare output.
- Data array and store merge stay in the controller.

Test Plan:
- Cold load 0x0000_0010, mem_rdata=0xDEADBEEF, ack after 3 cycles -> one REFILL, mem_addr=0x10, stall high until ack. Replay cycle gives cpu_rdata=0xDEADBEEF with stall=0. Final counts: miss_count=1, hit_count=0.
- Then sb 0xAA to 0x13 and sh 0x1234 to 0x10 -> both hit with no stall. Load 0x10 returns 0xAAADEAD34? No: returns 0xAAAD1234 (byte 3 = AA, low half = 1234). hit_count=3, dirty=1.
- Conflicting load 0x0000_0030 (same index) -> WRITEBACK with mem_we=1, mem_addr=0x10, mem_wdata=0xAAAD1234. Then REFILL with mem_addr=0x30.
- Hold mem_ack low 10 cycles during WRITEBACK -> mem_req, mem_addr and mem_wdata stable, stall high throughout.
- Assert rst_n low mid-REFILL -> immediately mem_req=0, stall=0, counters=0. A following load to the same address misses.
- Store miss with sw=sh=sb=1, data 0x11223344, addr 0x44 -> refill, then replay merges a full word (sw priority). Subsequent load returns 0x11223344.
